// File: rtl/uart_tx_serializer.sv
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : UART transmit serializer. Accepts one word over a
//                valid/ready handshake and shifts it out LSB-first as
//                start bit, DATA_BITS data bits, optional even-parity bit
//                and STOP_BITS stop bits. The line advances one bit per
//                baud_tick and idles high.
//                Optional parity bit: define UART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,      // asynchronous, active low
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 tx_next;
`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_next;
`endif

  // State, datapath and registered handshake outputs; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
      tx       <= tx_next;
      // Ready/busy track the state the FSM is entering so they change with it.
      tx_ready <= (state_next == IDLE);
      tx_busy  <= (state_next != IDLE);
`ifdef UART_TX_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end

  // Next-state and datapath logic; every bit transition after accept waits for baud_tick.
  always_comb begin
    state_next    = state;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    tx_next       = tx;
    tx_done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity;
`endif

    case (state)
      IDLE: begin
        // Ticks here are ignored; the start bit is aligned to the grid in SYNC.
        if (tx_valid) begin
          shift_next  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_next = ^tx_data;
`endif
          state_next  = SYNC;
        end
      end

      SYNC: begin
        if (baud_tick) begin
          tx_next    = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (baud_tick) begin
          tx_next      = shift[0];
          shift_next   = {1'b0, shift[DATA_BITS-1:1]};
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_next       = parity;
            state_next    = PARITY;
`else
            tx_next       = 1'b1;
            stop_cnt_next = 1'b0;
            state_next    = STOP;
`endif
          end else begin
            tx_next      = shift[0];
            shift_next   = {1'b0, shift[DATA_BITS-1:1]};
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = STOP;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          if (stop_cnt == LAST_STOP) begin
            // The done pulse marks the tick that closes the last stop bit.
            tx_done    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream consumer of the baud tick generator: serialises one byte per frame onto the UART TX line, advancing one bit per baud_tick.
- Accepts bytes from the host side over a valid/ready handshake.
- Frame format is LSB-first: start bit (0), DATA_BITS data bits, optional parity bit, then STOP_BITS stop bits (1).
- The line idles high.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; the same clock as the baud generator.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- baud_tick  input  1  one-clk-wide pulse, once per bit period, from the baud generator.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  host has a byte on tx_data.
- tx_ready  output  1  block can accept a byte; high only in IDLE.
- tx_busy  output  1  frame in progress; equals !tx_ready.
- tx_done  output  1  one-clk pulse when the last stop bit period ends.
- tx  output  1  serial line output, registered.

Behaviour:
- Reset (reset=0), taking effect immediately and asynchronously:
  - state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register and counters cleared.
  - Asserting reset mid-frame aborts the frame; tx returns to 1 with no glitch low.
- Accept: on a clk edge with state=IDLE and tx_valid=1:
  - tx_data is latched into the shift register; state becomes SYNC.
  - tx_ready drops the following cycle.
  - A tx_valid edge outside IDLE is ignored; no byte is queued and nothing is dropped silently, because the host must hold tx_valid until it sees ready.
- FSM: IDLE -> SYNC -> START -> DATA -> [PARITY] -> STOP -> IDLE. All transitions except IDLE->SYNC occur only on edges where baud_tick=1.
  - SYNC, on tick: tx<=0; go to START. This aligns the start bit to the bit grid, so the start-bit edge lags accept by 1..BAUD_DIV clks.
  - START, on tick: tx<=shift[0]; shift right; bit_cnt<=0; go to DATA.
  - DATA, on tick with bit_cnt<DATA_BITS-1: tx<=shift[0]; shift right; bit_cnt+1.
  - DATA, on tick with bit_cnt==DATA_BITS-1: go to PARITY (if compiled in), else tx<=1 and go to STOP with stop_cnt<=0.
  - STOP, on tick with stop_cnt<STOP_BITS-1: stop_cnt+1; tx stays 1.
  - STOP, on tick with stop_cnt==STOP_BITS-1: go to IDLE; tx_done=1 for exactly that one cycle; tx_ready=1 from the next cycle.
- Every bit, including the start bit, holds on tx for exactly one tick interval.
- Back-to-back: if tx_valid is held high, the next byte is accepted on the first cycle in IDLE. The inter-frame gap is 1 clk plus the SYNC wait.
- baud_tick pulses while in IDLE are ignored.
- baud_tick coinciding with the accept edge does not advance SYNC; the state enters SYNC on that edge.
- tx_busy = (state != IDLE), registered alongside tx_ready.
- Widths:
  - bit_cnt is $clog2(DATA_BITS) bits; stop_cnt is 1 bit.
  - The parity register is the XOR of the latched data bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - On accept, even parity is computed over tx_data[DATA_BITS-1:0] and stored.
  - After the last data bit, on tick: tx<=parity; go to PARITY.
  - PARITY, on tick: tx<=1; go to STOP.
  - Frame length = 1+DATA_BITS+1+STOP_BITS ticks.
- When undefined: no PARITY state or register; frame length = 1+DATA_BITS+STOP_BITS ticks.

Test Plan:
- Reset held low for 5 clks, with baud_tick driven every 4 clks -> tx=1, tx_ready=1, tx_done=0 throughout; no state change.
- Send 0xA5 (DATA_BITS=8, STOP_BITS=1, no parity), tick every 4 clks -> tx samples at each tick read 0,1,0,1,0,0,1,0,1,1; tx_done pulses once for 1 clk; tx_ready rises the next clk.
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit = 1; frame = 0,1,1,1,0,0,0,0,0,1,1.
- tx_valid held high with 0x55 then 0xFF, STOP_BITS=2 -> two complete frames, each stop period lasting 2 ticks; the second start bit begins on the first tick after SYNC; no byte is lost.
- Reset pulled low during DATA bit 3 of 0x00 -> tx=1 immediately (asynchronously, same cycle); tx_ready=1 after release; the next accepted byte 0x3C is sent correctly.
- tx_valid pulsed for 1 clk while busy -> ignored; tx_done count equals the number of accepted frames; the line pattern is unchanged.
